alu_rs: RTL and testbench
=========================

// Module: alu_rs
// PURPOSE
//  ALU reservation station: the receiving end of the decoder's ALU dispatch bus.
//  Buffers up to DEPTH dispatched ALU ops and snoops the common data bus (CDB) for pending source tags.
//  Issues one operand-complete op per cycle to the ALU through a registered valid/ready stage.
//  Drives the stall that freezes PC fetch and dispatch while it is full.
// PARAMETERS
//  DEPTH       4       number of RS entries (2..16)
//  OP_W        5       operation code width (simp_op)
//  LOCK_W      4       source/dest tag width; low ROB_ENT_W bits = ROB entry
//  ROB_ENT_W   3       ROB entry index width
//  NO_LOCK     4'b1000 tag value meaning "operand holds data, not waiting"
//  DATA_W      32      operand width
// PORTS
//  clk        in   1        clock, rising edge
//  rst        in   1        reset: synchronous, active-high
//  flush      in   1        discard all in-flight ops (mispredict)
//  dec_write  in   1        dispatch request
//  dec_bus    in   BUS_W    {op, lock1, data1, lock2, data2, dest_tag}; BUS_W = OP_W + 3*LOCK_W + 2*DATA_W
//  dec_stall  out  1        RS full; the request is not accepted
//  cdb_valid  in   1        CDB broadcast valid
//  cdb_tag    in   LOCK_W   tag of broadcast result
//  cdb_data   in   DATA_W   broadcast result value
//  ex_valid   out  1        issue register holds an op
//  ex_ready   in   1        ALU accepts the op this cycle
//  ex_op      out  OP_W     operation code
//  ex_a       out  DATA_W   operand A
//  ex_b       out  DATA_W   operand B
//  ex_tag     out  LOCK_W   destination tag (ROB entry)
// BEHAVIOUR
//  Reset / flush (sync; flush has the same effect as rst):
//   - clears all entry valid bits and ex_valid; ex_op, ex_a, ex_b and ex_tag go to 0.
//   - has priority over dispatch, snoop and issue in the same cycle.
//  Stall:
//   - dec_stall = &entry_valid, from registered state, combinational out.
//   - dec_write while dec_stall is ignored; the decoder holds the bus.
//  Dispatch, on dec_write && !dec_stall:
//   - writes the lowest-index free entry at the clock edge.
//   - same-cycle bypass: for each source, if lockN != NO_LOCK && cdb_valid && cdb_tag == lockN,
//     store cdb_data with tag NO_LOCK.
//  Snoop:
//   - every valid entry whose srcN tag == cdb_tag with cdb_valid set captures cdb_data
//     and sets that tag to NO_LOCK.
//   - both sources may wake in the same cycle.
//  Ready:
//   - an entry is ready when both stored tags == NO_LOCK, judged on registered state.
//   - a value captured this edge makes the entry issuable next cycle.
//  Issue:
//   - the issue register loads when !ex_valid || ex_ready.
//   - source is the lowest-index ready entry; that entry is freed at the same edge.
//   - if no entry is ready and ex_ready, ex_valid falls to 0.
//   - while ex_valid && !ex_ready, all ex_* outputs hold stable.
//  Freed entry:
//   - is reusable from the next cycle; dec_stall drops one cycle after the issue edge.
//  Latency:
//   - op dispatched ready at edge E -> ex_valid high after edge E+1.
//   - CDB wakeup at edge W -> ex_valid earliest after edge W+1.
//  NO_LOCK broadcasts: cdb_tag == NO_LOCK never matches an entry.
//  Simultaneous events: dispatch + issue + snoop in one cycle are all performed.
// TESTING
//  1 Ready dispatch op=ADD, a=5, b=7, dest=2 -> after 2 edges ex_valid=1, ex_a=5, ex_b=7, ex_tag=2.
//  2 lock1=3 pending; CDB tag 3 data 0x10 two cycles later -> issue next cycle, ex_a=0x10.
//  3 Dispatch lock2=5 while CDB tag 5 data 0xAB in the same cycle -> issues with ex_b=0xAB, no extra wait.
//  4 Four unready ops -> dec_stall=1 and the 5th is ignored; one wakeup -> issue, then dec_stall=0 next cycle.
//  5 ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* stable; ex_ready=1 -> next ready op loads.
//  6 flush with 3 valid entries and ex_valid=1 -> next cycle ex_valid=0, dec_stall=0,
//    and no later issue of the flushed ops.

Source files
------------

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station buffering dispatched ops, snooping the CDB for
// pending source tags and issuing one operand-complete op per cycle to the ALU.
module alu_rs #(
    parameter int DEPTH = 4,
    parameter int OP_W = 5,
    parameter int LOCK_W = 4,
    parameter int ROB_ENT_W = 3,
    parameter logic [LOCK_W-1:0] NO_LOCK = 4'b1000,
    parameter int DATA_W = 32,
    localparam int BUS_W = OP_W + 3*LOCK_W + 2*DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              dec_write,
    input  logic [BUS_W-1:0]  dec_bus,
    output logic              dec_stall,
    input  logic              cdb_valid,
    input  logic [LOCK_W-1:0] cdb_tag,
    input  logic [DATA_W-1:0] cdb_data,
    output logic              ex_valid,
    input  logic              ex_ready,
    output logic [OP_W-1:0]   ex_op,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [LOCK_W-1:0] ex_tag
);
    localparam int IDX_W = $clog2(DEPTH);

    if (DEPTH < 2 || DEPTH > 16 || ROB_ENT_W >= LOCK_W) begin : g_bad_params
        $error("alu_rs: unsupported parameter combination");
    end

    logic [DEPTH-1:0]  r_valid;
    logic [OP_W-1:0]   r_op    [DEPTH];
    logic [LOCK_W-1:0] r_lock1 [DEPTH];
    logic [DATA_W-1:0] r_data1 [DEPTH];
    logic [LOCK_W-1:0] r_lock2 [DEPTH];
    logic [DATA_W-1:0] r_data2 [DEPTH];
    logic [LOCK_W-1:0] r_dest  [DEPTH];

    logic              r_ex_valid;
    logic [OP_W-1:0]   r_ex_op;
    logic [DATA_W-1:0] r_ex_a;
    logic [DATA_W-1:0] r_ex_b;
    logic [LOCK_W-1:0] r_ex_tag;

    logic [OP_W-1:0]   w_d_op;
    logic [LOCK_W-1:0] w_d_l1;
    logic [DATA_W-1:0] w_d_d1;
    logic [LOCK_W-1:0] w_d_l2;
    logic [DATA_W-1:0] w_d_d2;
    logic [LOCK_W-1:0] w_d_dest;

    logic              w_cdb_hit;
    logic              w_full;
    logic              w_issue_en;
    logic              w_accept;
    logic [DEPTH-1:0]  w_ready;
    logic [DEPTH-1:0]  w_hit1;
    logic [DEPTH-1:0]  w_hit2;
    logic              w_any_rdy;
    logic [IDX_W-1:0]  w_rdy_idx;
    logic [IDX_W-1:0]  w_free_idx;

    assign {w_d_op, w_d_l1, w_d_d1, w_d_l2, w_d_d2, w_d_dest} = dec_bus;

    // a NO_LOCK broadcast must never wake anything, so it is masked once here
    assign w_cdb_hit  = cdb_valid && (cdb_tag != NO_LOCK);
    assign w_full     = &r_valid;
    assign w_issue_en = !r_ex_valid || ex_ready;
    assign w_accept   = dec_write && !w_full;

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        assign w_ready[e] = r_valid[e] && (r_lock1[e] == NO_LOCK) && (r_lock2[e] == NO_LOCK);
        assign w_hit1[e]  = r_valid[e] && w_cdb_hit && (r_lock1[e] == cdb_tag);
        assign w_hit2[e]  = r_valid[e] && w_cdb_hit && (r_lock2[e] == cdb_tag);
    end

    always_comb begin
        w_any_rdy  = 1'b0;
        w_rdy_idx  = '0;
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_any_rdy = 1'b1;
                w_rdy_idx = IDX_W'(i);
            end
            if (!r_valid[i]) w_free_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_valid    <= '0;
            r_ex_valid <= 1'b0;
            r_ex_op    <= '0;
            r_ex_a     <= '0;
            r_ex_b     <= '0;
            r_ex_tag   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_hit1[i]) begin
                    r_lock1[i] <= NO_LOCK;
                    r_data1[i] <= cdb_data;
                end
                if (w_hit2[i]) begin
                    r_lock2[i] <= NO_LOCK;
                    r_data2[i] <= cdb_data;
                end
            end
            if (w_issue_en) begin
                r_ex_valid <= w_any_rdy;
                if (w_any_rdy) begin
                    r_ex_op              <= r_op[w_rdy_idx];
                    r_ex_a               <= r_data1[w_rdy_idx];
                    r_ex_b               <= r_data2[w_rdy_idx];
                    r_ex_tag             <= r_dest[w_rdy_idx];
                    r_valid[w_rdy_idx]   <= 1'b0;
                end
            end
            // the free slot is never the issuing slot, so both writes can land together
            if (w_accept) begin
                r_valid[w_free_idx] <= 1'b1;
                r_op[w_free_idx]    <= w_d_op;
                r_dest[w_free_idx]  <= w_d_dest;
                r_lock1[w_free_idx] <= (w_cdb_hit && w_d_l1 == cdb_tag) ? NO_LOCK : w_d_l1;
                r_data1[w_free_idx] <= (w_cdb_hit && w_d_l1 == cdb_tag) ? cdb_data : w_d_d1;
                r_lock2[w_free_idx] <= (w_cdb_hit && w_d_l2 == cdb_tag) ? NO_LOCK : w_d_l2;
                r_data2[w_free_idx] <= (w_cdb_hit && w_d_l2 == cdb_tag) ? cdb_data : w_d_d2;
            end
        end
    end

    assign dec_stall = w_full;
    assign ex_valid  = r_ex_valid;
    assign ex_op     = r_ex_op;
    assign ex_a      = r_ex_a;
    assign ex_b      = r_ex_b;
    assign ex_tag    = r_ex_tag;
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed scenarios plus randomized traffic against an entry-list reference model.
module tb_alu_rs;
    localparam int DEPTH = 4, OP_W = 5, LOCK_W = 4, DATA_W = 32;
    localparam int BUS_W = OP_W + 3*LOCK_W + 2*DATA_W;
    localparam logic [3:0] NL = 4'b1000;

    logic              clk = 1'b0;
    logic              rst = 1'b1, flush = 1'b0, dec_write = 1'b0;
    logic              cdb_valid = 1'b0, ex_ready = 1'b1;
    logic [LOCK_W-1:0] cdb_tag = '0;
    logic [DATA_W-1:0] cdb_data = '0;
    logic [BUS_W-1:0]  dec_bus;
    logic              dec_stall, ex_valid;
    logic [OP_W-1:0]   ex_op;
    logic [DATA_W-1:0] ex_a, ex_b;
    logic [LOCK_W-1:0] ex_tag;

    logic [4:0]  d_op = '0;
    logic [3:0]  d_l1 = NL, d_l2 = NL, d_dst = '0;
    logic [31:0] d_d1 = '0, d_d2 = '0;
    assign dec_bus = {d_op, d_l1, d_d1, d_l2, d_d2, d_dst};

    alu_rs dut (
        .clk(clk), .rst(rst), .flush(flush), .dec_write(dec_write), .dec_bus(dec_bus),
        .dec_stall(dec_stall), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op), .ex_a(ex_a), .ex_b(ex_b),
        .ex_tag(ex_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v;
        logic [4:0]  op;
        logic [3:0]  l1;
        logic [31:0] d1;
        logic [3:0]  l2;
        logic [31:0] d2;
        logic [3:0]  dst;
    } ent_t;

    ent_t        m[DEPTH];
    bit          m_exv;
    logic [4:0]  m_op;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_tag;
    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_full();
        foreach (m[i]) if (!m[i].v) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit wakes(input logic [3:0] t);
        return cdb_valid && cdb_tag != NL && t == cdb_tag;
    endfunction

    task automatic model_edge();
        ent_t n[DEPTH];
        ent_t e;
        int fr = -1, rd = -1;
        if (rst || flush) begin
            foreach (m[i]) m[i].v = 1'b0;
            m_exv = 1'b0; m_op = '0; m_a = '0; m_b = '0; m_tag = '0;
            return;
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!m[i].v) fr = i;
            if (m[i].v && m[i].l1 == NL && m[i].l2 == NL) rd = i;
        end
        n = m;
        foreach (n[i]) if (n[i].v) begin
            if (wakes(n[i].l1)) begin n[i].l1 = NL; n[i].d1 = cdb_data; end
            if (wakes(n[i].l2)) begin n[i].l2 = NL; n[i].d2 = cdb_data; end
        end
        if (!m_exv || ex_ready) begin
            m_exv = (rd >= 0);
            if (rd >= 0) begin
                m_op = m[rd].op; m_a = m[rd].d1; m_b = m[rd].d2; m_tag = m[rd].dst;
                n[rd].v = 1'b0;
            end
        end
        if (dec_write && fr >= 0) begin
            e = '{1'b1, d_op, d_l1, d_d1, d_l2, d_d2, d_dst};
            if (wakes(e.l1)) begin e.l1 = NL; e.d1 = cdb_data; end
            if (wakes(e.l2)) begin e.l2 = NL; e.d2 = cdb_data; end
            n[fr] = e;
        end
        m = n;
    endtask

    task automatic step();
        check("ex_valid", ex_valid, m_exv);
        check("dec_stall", dec_stall, m_full());
        check("ex_op", ex_op, m_op);
        check("ex_a", ex_a, m_a);
        check("ex_b", ex_b, m_b);
        check("ex_tag", ex_tag, m_tag);
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [4:0] op, input logic [3:0] l1, input logic [31:0] a,
                       input logic [3:0] l2, input logic [31:0] b, input logic [3:0] dst);
        dec_write = 1'b1; d_op = op; d_l1 = l1; d_d1 = a; d_l2 = l2; d_d2 = b; d_dst = dst;
    endtask

    task automatic idle();
        dec_write = 1'b0; cdb_valid = 1'b0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        model_edge();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        do_reset();
        step();

        // 1: ready op, two edges to the issue register
        ex_ready = 1'b1;
        put(5'd1, NL, 32'd5, NL, 32'd7, 4'd2); step();
        idle(); step();
        check("t1_valid", ex_valid, 1'b1);
        check("t1_a", ex_a, 32'd5);
        check("t1_b", ex_b, 32'd7);
        check("t1_tag", ex_tag, 4'd2);

        // 2: pending lock1=3 woken two cycles later
        put(5'd2, 4'd3, 32'd0, NL, 32'd1, 4'd4); step();
        idle(); step();
        cdb_valid = 1'b1; cdb_tag = 4'd3; cdb_data = 32'h10; step();
        idle();
        check("t2_wait", ex_valid, 1'b0);
        step();
        check("t2_valid", ex_valid, 1'b1);
        check("t2_a", ex_a, 32'h10);

        // 3: dispatch with same-cycle CDB bypass on lock2
        put(5'd3, NL, 32'd9, 4'd5, 32'd0, 4'd6);
        cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 32'hAB; step();
        idle(); step();
        check("t3_valid", ex_valid, 1'b1);
        check("t3_b", ex_b, 32'hAB);
        check("t3_tag", ex_tag, 4'd6);

        // 4: fill with unready ops, 5th ignored, one wakeup frees a slot
        do_reset();
        for (int i = 0; i < 4; i++) begin
            put(5'd4, 4'(i + 1), 32'd0, NL, 32'd0, 4'(i)); step();
        end
        check("t4_full", dec_stall, 1'b1);
        put(5'd5, NL, 32'd1, NL, 32'd2, 4'd9); step();
        idle();
        cdb_valid = 1'b1; cdb_tag = 4'd2; cdb_data = 32'h55; step();
        idle(); step();
        check("t4_issue", ex_valid, 1'b1);
        check("t4_tag", ex_tag, 4'd1);
        check("t4_a", ex_a, 32'h55);
        check("t4_unstall", dec_stall, 1'b0);

        // 5: back-pressure holds outputs
        do_reset();
        ex_ready = 1'b0;
        put(5'd6, NL, 32'hA, NL, 32'hB, 4'd1); step();
        put(5'd7, NL, 32'hC, NL, 32'hD, 4'd2); step();
        idle();
        for (int i = 0; i < 3; i++) begin
            check("t5_hold_v", ex_valid, 1'b1);
            check("t5_hold_tag", ex_tag, 4'd1);
            check("t5_hold_a", ex_a, 32'hA);
            step();
        end
        ex_ready = 1'b1; step();
        check("t5_next_tag", ex_tag, 4'd2);
        check("t5_next_a", ex_a, 32'hC);

        // 6: flush with 3 entries and a held issue
        do_reset();
        ex_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put(5'd8, NL, 32'(i), NL, 32'(i), 4'(i)); step();
        end
        idle(); flush = 1'b1; step();
        flush = 1'b0;
        check("t6_valid", ex_valid, 1'b0);
        check("t6_stall", dec_stall, 1'b0);
        ex_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("t6_no_issue", ex_valid, 1'b0);
            step();
        end

        // randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            flush = ($urandom_range(0, 99) == 0);
            ex_ready = ($urandom_range(0, 9) < 7);
            cdb_valid = $urandom_range(0, 1);
            cdb_tag = 4'($urandom_range(0, 8));
            cdb_data = $urandom;
            if (!(dec_write && dec_stall)) begin
                dec_write = $urandom_range(0, 1);
                d_op = 5'($urandom);
                d_l1 = ($urandom_range(0, 2) == 0) ? NL : 4'($urandom_range(0, 7));
                d_l2 = ($urandom_range(0, 2) == 0) ? NL : 4'($urandom_range(0, 7));
                d_d1 = $urandom; d_d2 = $urandom;
                d_dst = 4'($urandom_range(0, 7));
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
